// File: rtl/tape_player_pkg.sv
// Shared definitions for the tape transmitter: FSM state encoding,
// standard ROM timing defaults and counter widths.
package tape_player_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PILOT,
      S_SYNC1,
      S_SYNC2,
      S_DATA,
      S_PAUSE
   } tape_state_t;

   // Duration counter must hold the 1 s pause in T-states.
   localparam int DUR_W  = 22;
   localparam int PCNT_W = 13;

   localparam int STD_CLK_PER_T  = 4;
   localparam int STD_PILOT_T    = 2168;
   localparam int STD_SYNC1_T    = 667;
   localparam int STD_SYNC2_T    = 735;
   localparam int STD_ZERO_T     = 855;
   localparam int STD_ONE_T      = 1710;
   localparam int STD_PILOT_HDR  = 8063;
   localparam int STD_PILOT_DATA = 3223;
   localparam int STD_PAUSE_T    = 3500000;

endpackage

// File: rtl/tape_tick_gen.sv
// T-state prescaler: one tick every CLK_PER_T clocks while en is high.
// Ports: clock, reset (async, low), en, turbo (tick every clock) -> tick.
module tape_tick_gen #(
   parameter int CLK_PER_T = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic turbo,
   output logic tick
);

   localparam int CW = (CLK_PER_T > 1) ? $clog2(CLK_PER_T) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_T - 1);

   logic [CW-1:0] cnt;
   // turbo is only sampled at tick boundaries so a tick is never cut short.
   logic          turbo_q;

   assign tick = en && (turbo_q || (cnt == LAST));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         turbo_q <= 1'b0;
      end else if (!en || tick) begin
         cnt     <= '0;
         turbo_q <= turbo;
      end else begin
         cnt     <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/tape_player.sv
// ZX ROM-standard tape waveform transmitter (pilot, sync, data, pause).
// Ports: clock, reset (async, low), stop, byte_data/valid/last/ready,
// tape_level, busy, underrun; turbo only when TAPE_TURBO_EN is defined.
module tape_player
   import tape_player_pkg::*;
#(
   parameter int CLK_PER_T  = STD_CLK_PER_T,
   parameter int PILOT_T    = STD_PILOT_T,
   parameter int SYNC1_T    = STD_SYNC1_T,
   parameter int SYNC2_T    = STD_SYNC2_T,
   parameter int ZERO_T     = STD_ZERO_T,
   parameter int ONE_T      = STD_ONE_T,
   parameter int PILOT_HDR  = STD_PILOT_HDR,
   parameter int PILOT_DATA = STD_PILOT_DATA,
   parameter int PAUSE_T    = STD_PAUSE_T
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       stop,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   input  logic       byte_last,
`ifdef TAPE_TURBO_EN
   input  logic       turbo,
`endif
   output logic       byte_ready,
   output logic       tape_level,
   output logic       busy,
   output logic       underrun
);

   tape_state_t       state;
   logic [DUR_W-1:0]  dur;
   logic [PCNT_W-1:0] pilot;
   logic [7:0]        shreg;
   logic [2:0]        bit_cnt;
   logic              half;
   logic              last_q;
   // Holds byte_ready low until the first clock after reset release.
   logic              armed;
   logic              tick;
   logic              turbo_sel;
   logic              expire;
   logic              byte_end;
   logic              accept;

`ifdef TAPE_TURBO_EN
   assign turbo_sel = turbo;
`else
   assign turbo_sel = 1'b0;
`endif

   tape_tick_gen #(
      .CLK_PER_T(CLK_PER_T)
   ) u_tick (
      .clock(clock),
      .reset(reset),
      .en   (busy),
      .turbo(turbo_sel),
      .tick (tick)
   );

   function automatic logic [DUR_W-1:0] bit_len(input logic b);
      return b ? DUR_W'(ONE_T) : DUR_W'(ZERO_T);
   endfunction

   assign busy     = (state != S_IDLE);
   assign expire   = tick && (dur == DUR_W'(1));
   assign byte_end = (state == S_DATA) && expire && half &&
                     (bit_cnt == 3'd0);
   // Mid-block ready is only offered on the clock the byte finishes.
   assign byte_ready = armed && !stop &&
                       ((state == S_IDLE) || (byte_end && !last_q));
   assign accept     = byte_valid && byte_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         dur        <= '0;
         pilot      <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         half       <= 1'b0;
         last_q     <= 1'b0;
         armed      <= 1'b0;
         tape_level <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (stop) begin
            state      <= S_IDLE;
            tape_level <= 1'b0;
            dur        <= '0;
            pilot      <= '0;
            bit_cnt    <= '0;
            half       <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (accept) begin
                     shreg    <= byte_data;
                     last_q   <= byte_last;
                     underrun <= 1'b0;
                     pilot    <= byte_data[7] ? PCNT_W'(PILOT_DATA)
                                              : PCNT_W'(PILOT_HDR);
                     dur      <= DUR_W'(PILOT_T);
                     state    <= S_PILOT;
                  end
               end
               S_PILOT: begin
                  if (expire) begin
                     tape_level <= ~tape_level;
                     if (pilot == PCNT_W'(1)) begin
                        dur   <= DUR_W'(SYNC1_T);
                        state <= S_SYNC1;
                     end else begin
                        pilot <= pilot - 1'b1;
                        dur   <= DUR_W'(PILOT_T);
                     end
                  end else if (tick) begin
                     dur <= dur - 1'b1;
                  end
               end
               S_SYNC1: begin
                  if (expire) begin
                     tape_level <= ~tape_level;
                     dur        <= DUR_W'(SYNC2_T);
                     state      <= S_SYNC2;
                  end else if (tick) begin
                     dur <= dur - 1'b1;
                  end
               end
               S_SYNC2: begin
                  if (expire) begin
                     tape_level <= ~tape_level;
                     dur        <= bit_len(shreg[7]);
                     bit_cnt    <= 3'd7;
                     half       <= 1'b0;
                     state      <= S_DATA;
                  end else if (tick) begin
                     dur <= dur - 1'b1;
                  end
               end
               S_DATA: begin
                  if (expire) begin
                     tape_level <= ~tape_level;
                     if (!half) begin
                        half <= 1'b1;
                        dur  <= bit_len(shreg[7]);
                     end else if (bit_cnt != 3'd0) begin
                        half    <= 1'b0;
                        bit_cnt <= bit_cnt - 1'b1;
                        shreg   <= {shreg[6:0], 1'b0};
                        dur     <= bit_len(shreg[6]);
                     end else if (accept) begin
                        half    <= 1'b0;
                        bit_cnt <= 3'd7;
                        shreg   <= byte_data;
                        last_q  <= byte_last;
                        dur     <= bit_len(byte_data[7]);
                     end else begin
                        // Block ended or source starved: silence.
                        half       <= 1'b0;
                        underrun   <= underrun | ~last_q;
                        tape_level <= 1'b0;
                        dur        <= DUR_W'(PAUSE_T);
                        state      <= S_PAUSE;
                     end
                  end else if (tick) begin
                     dur <= dur - 1'b1;
                  end
               end
               S_PAUSE: begin
                  if (expire) begin
                     dur   <= '0;
                     state <= S_IDLE;
                  end else if (tick) begin
                     dur <= dur - 1'b1;
                  end
               end
               default: begin
                  state      <= S_IDLE;
                  tape_level <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player with shortened timing constants.
// Expected edge times come from a waveform table built in the bench.
module tb_tape_player;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       byte_valid = 1'b0;
   logic       byte_last = 1'b0;
   logic       turbo = 1'b0;
   logic       byte_ready;
   logic       tape_level;
   logic       busy;
   logic       underrun;

   int nvec = 0;
   int nfail = 0;
   int exp_q[$];
   int exp_end;

   always #5 clock = ~clock;

   tape_player #(
      .CLK_PER_T (1),
      .PILOT_T   (4),
      .SYNC1_T   (2),
      .SYNC2_T   (3),
      .ZERO_T    (2),
      .ONE_T     (4),
      .PILOT_HDR (3),
      .PILOT_DATA(5),
      .PAUSE_T   (10)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .stop      (stop),
      .byte_data (byte_data),
      .byte_valid(byte_valid),
      .byte_last (byte_last),
`ifdef TAPE_TURBO_EN
      .turbo     (turbo),
`endif
      .byte_ready(byte_ready),
      .tape_level(tape_level),
      .busy      (busy),
      .underrun  (underrun)
   );

   task automatic check(input string tag, input int got, input int want);
      nvec++;
      if (got != want) begin
         nfail++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   // Edge times (clocks after accept) of pilot, sync and bit pulses.
   // The final bit pulse ends in the forced-low pause, so no edge.
   task automatic build_exp(input int npilot, input int nbits,
                            input logic [15:0] bits);
      int t;
      int len;
      exp_q.delete();
      t = 0;
      for (int i = 0; i < npilot; i++) begin
         t += 4;
         exp_q.push_back(t);
      end
      t += 2;
      exp_q.push_back(t);
      t += 3;
      exp_q.push_back(t);
      for (int i = nbits - 1; i >= 0; i--) begin
         len = bits[i] ? 4 : 2;
         t += len;
         exp_q.push_back(t);
         t += len;
         exp_q.push_back(t);
      end
      void'(exp_q.pop_back());
      exp_end = t + 10;
   endtask

   task automatic accept(input logic [7:0] d, input logic l,
                         input logic hold, input logic [7:0] nd,
                         input logic nl);
      @(negedge clock);
      byte_data  = d;
      byte_last  = l;
      byte_valid = 1'b1;
      check("rdy_idle", byte_ready, 1);
      @(posedge clock);
      #1;
      byte_data  = nd;
      byte_last  = nl;
      byte_valid = hold;
   endtask

   task automatic measure(input string tag, input int nrdy_exp);
      int   got[$];
      logic prev;
      int   fall;
      int   nrdy;
      int   tmo;
      prev = 1'b0;
      fall = -1;
      nrdy = 0;
      tmo  = 1;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clock);
         if (tape_level !== prev) begin
            got.push_back(k);
            prev = tape_level;
         end
         if (!busy) begin
            fall       = k;
            tmo        = 0;
            byte_valid = 1'b0;
            break;
         end
         if (byte_ready) nrdy++;
      end
      check({tag, "_tmo"}, tmo, 0);
      check({tag, "_nedge"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s_e%0d", tag, i),
               (i < got.size()) ? got[i] : -1, exp_q[i]);
      end
      check({tag, "_fall"}, fall, exp_end);
      check({tag, "_nrdy"}, nrdy, nrdy_exp);
      check({tag, "_lvl"}, tape_level, 0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check("rst_lvl", tape_level, 0);
      check("rst_busy", busy, 0);
      check("rst_rdy", byte_ready, 0);
      check("rst_urun", underrun, 0);
      reset = 1'b1;
      @(negedge clock);

      // Header byte 0x00: 3 pilot pulses, sixteen short pulses.
      build_exp(3, 8, 16'h0000);
      accept(8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      measure("b00", 0);

      // Data byte 0xFF: 5 pilot pulses, sixteen long pulses.
      build_exp(5, 8, 16'h00FF);
      accept(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
      measure("bFF", 0);

      // Two-byte block, valid held: one mid-block ready, no gap.
      build_exp(5, 16, 16'h8001);
      accept(8'h80, 1'b0, 1'b1, 8'h01, 1'b1);
      measure("b2", 1);
      check("b2_urun", underrun, 0);

      // Starved block: underrun after the first byte.
      build_exp(5, 8, 16'h0080);
      accept(8'h80, 1'b0, 1'b0, 8'h00, 1'b0);
      measure("urun", 1);
      check("urun_set", underrun, 1);

      // Next accept clears underrun; then stop in DATA.
      accept(8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      @(negedge clock);
      check("urun_clr", underrun, 0);
      repeat (25) @(negedge clock);
      check("pre_stop_lvl", tape_level, 1);
      check("pre_stop_busy", busy, 1);
      stop       = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      #1;
      check("stop_rdy", byte_ready, 0);
      @(negedge clock);
      check("stop_busy", busy, 0);
      check("stop_lvl", tape_level, 0);
      check("stop_rdy2", byte_ready, 0);
      @(negedge clock);
      check("stop_busy2", busy, 0);
      stop       = 1'b0;
      byte_valid = 1'b0;
      @(negedge clock);
      check("post_stop_busy", busy, 0);
      check("post_stop_urun", underrun, 0);

      // Reset in the middle of the pilot.
      accept(8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      repeat (7) @(negedge clock);
      check("pre_rst_lvl", tape_level, 1);
      reset = 1'b0;
      #1;
      check("mid_rst_lvl", tape_level, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rdy", byte_ready, 0);
      @(negedge clock);
      check("mid_rst_rdy2", byte_ready, 0);
      reset = 1'b1;
      #1;
      check("rel_rdy0", byte_ready, 0);
      @(negedge clock);
      check("rel_rdy1", byte_ready, 1);
      check("rel_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
